// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin sharing of the rf write port between two writeback requesters
// Build option: define RF_BYPASS_EN to forward the pending write onto BusA_out/BusB_out.
module rf_write_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Resetb,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  output logic [AW-1:0]    RW,
  output logic [DW-1:0]    BusW,
  output logic             RegWr,
  input  logic [AW-1:0]    RA_in,
  input  logic [AW-1:0]    RB_in,
  input  logic [DW-1:0]    BusA_rf,
  input  logic [DW-1:0]    BusB_rf,
  output logic [DW-1:0]    BusA_out,
  output logic [DW-1:0]    BusB_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] zero_wr_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic          slot0Valid, slot1Valid;
  logic [AW-1:0] slot0Addr, slot1Addr;
  logic [DW-1:0] slot0Data, slot1Data;
  logic          lastGrant;

  logic          grant0, grant1, anyGrant, bothValid;
  logic          accept0, accept1;
  logic [AW-1:0] grantAddr;
  logic [DW-1:0] grantData;

  // Under contention the requester that did not win last time goes first.
  always_comb begin
    bothValid = slot0Valid & slot1Valid;
    grant0    = slot0Valid & (~slot1Valid | lastGrant);
    grant1    = slot1Valid & (~slot0Valid | ~lastGrant);
    anyGrant  = grant0 | grant1;
    grantAddr = grant1 ? slot1Addr : slot0Addr;
    grantData = grant1 ? slot1Data : slot0Data;
  end

  assign req0_ready = Resetb & (~slot0Valid | grant0);
  assign req1_ready = Resetb & (~slot1Valid | grant1);
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      slot0Valid <= 1'b0;
      slot0Addr  <= '0;
      slot0Data  <= '0;
    end else if (accept0) begin
      slot0Valid <= 1'b1;
      slot0Addr  <= req0_addr;
      slot0Data  <= req0_data;
    end else if (grant0) begin
      slot0Valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      slot1Valid <= 1'b0;
      slot1Addr  <= '0;
      slot1Data  <= '0;
    end else if (accept1) begin
      slot1Valid <= 1'b1;
      slot1Addr  <= req1_addr;
      slot1Data  <= req1_data;
    end else if (grant1) begin
      slot1Valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      lastGrant <= 1'b1;
    end else if (anyGrant) begin
      lastGrant <= grant1;
    end
  end

  // A granted write to $0 still retires the slot but never reaches the rf.
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      RW    <= '0;
      BusW  <= '0;
      RegWr <= 1'b0;
    end else if (anyGrant) begin
      RW    <= grantAddr;
      BusW  <= grantData;
      RegWr <= (grantAddr != '0);
    end else begin
      RegWr <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      stall_cnt   <= '0;
      zero_wr_cnt <= '0;
    end else begin
      if (bothValid && (stall_cnt != CntMax)) begin
        stall_cnt <= stall_cnt + CntOne;
      end
      if (anyGrant && (grantAddr == '0) && (zero_wr_cnt != CntMax)) begin
        zero_wr_cnt <= zero_wr_cnt + CntOne;
      end
    end
  end

`ifdef RF_BYPASS_EN
  // Forward the write that the rf commits on the coming edge.
  always_comb begin
    BusA_out = BusA_rf;
    BusB_out = BusB_rf;
    if (RegWr && (RW == RA_in) && (RA_in != '0)) begin
      BusA_out = BusW;
    end
    if (RegWr && (RW == RB_in) && (RB_in != '0)) begin
      BusB_out = BusW;
    end
  end
`else
  logic unusedReadAddr;
  assign unusedReadAddr = ^{RA_in, RB_in};
  assign BusA_out = BusA_rf;
  assign BusB_out = BusB_rf;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed bench for rf_write_arbiter with a per-cycle reference model
module tb_rf_write_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 16;

  logic             Clk = 1'b0;
  logic             Resetb;
  logic             req0_valid, req1_valid;
  logic [AW-1:0]    req0_addr, req1_addr;
  logic [DW-1:0]    req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic [AW-1:0]    RW;
  logic [DW-1:0]    BusW;
  logic             RegWr;
  logic [AW-1:0]    RA_in, RB_in;
  logic [DW-1:0]    BusA_rf, BusB_rf, BusA_out, BusB_out;
  logic [CNT_W-1:0] stall_cnt, zero_wr_cnt;

  int   total = 0;
  int   bad   = 0;
  logic checkEn = 1'b0;

  rf_write_arbiter #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Resetb(Resetb),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .RA_in(RA_in), .RB_in(RB_in), .BusA_rf(BusA_rf), .BusB_rf(BusB_rf),
    .BusA_out(BusA_out), .BusB_out(BusB_out),
    .stall_cnt(stall_cnt), .zero_wr_cnt(zero_wr_cnt)
  );

  always #5 Clk = ~Clk;

  // Register file driven by the DUT's write port.
  logic [DW-1:0] rf [32] = '{default: '0};
  always @(posedge Clk) if (RegWr && RW != 0) rf[RW] <= BusW;
  assign BusA_rf = (RA_in == 0) ? '0 : rf[RA_in];
  assign BusB_rf = (RB_in == 0) ? '0 : rf[RB_in];

  // Reference model: pending entry per requester, winner per round-robin rule.
  logic          mPv [2];
  logic [AW-1:0] mPa [2];
  logic [DW-1:0] mPd [2];
  logic          mLast, mRegWr, mAny, mSel, mRdy0, mRdy1;
  logic [AW-1:0] mRW;
  logic [DW-1:0] mBusW;
  logic [CNT_W-1:0] mStall, mZero;
  logic [DW-1:0] mRf [32] = '{default: '0};

  always_comb begin
    mAny = mPv[0] || mPv[1];
    if (mPv[0] && mPv[1]) mSel = ~mLast;
    else                  mSel = mPv[1];
    mRdy0 = Resetb && (!mPv[0] || (mAny && mSel == 1'b0));
    mRdy1 = Resetb && (!mPv[1] || (mAny && mSel == 1'b1));
  end

  always @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      mPv[0] <= 1'b0; mPv[1] <= 1'b0;
      mLast <= 1'b1; mRW <= '0; mBusW <= '0; mRegWr <= 1'b0;
      mStall <= '0; mZero <= '0;
    end else begin
      if (mAny) begin
        mRW    <= mPa[mSel];
        mBusW  <= mPd[mSel];
        mRegWr <= (mPa[mSel] != 0);
        mLast  <= mSel;
        if (mPa[mSel] == 0 && mZero != '1) mZero <= mZero + 1'b1;
      end else begin
        mRegWr <= 1'b0;
      end
      if (mPv[0] && mPv[1] && mStall != '1) mStall <= mStall + 1'b1;
      if (req0_valid && mRdy0) begin
        mPv[0] <= 1'b1; mPa[0] <= req0_addr; mPd[0] <= req0_data;
      end else if (mAny && mSel == 1'b0) mPv[0] <= 1'b0;
      if (req1_valid && mRdy1) begin
        mPv[1] <= 1'b1; mPa[1] <= req1_addr; mPd[1] <= req1_data;
      end else if (mAny && mSel == 1'b1) mPv[1] <= 1'b0;
    end
  end

  always @(posedge Clk) if (mRegWr && mRW != 0) mRf[mRW] <= mBusW;

  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = (a == 0) ? '0 : mRf[a];
`ifdef RF_BYPASS_EN
    if (mRegWr && mRW == a && a != 0) v = mBusW;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (checkEn) begin
      check("RegWr", RegWr, mRegWr);
      check("RW", RW, mRW);
      check("BusW", BusW, mBusW);
      check("req0_ready", req0_ready, mRdy0);
      check("req1_ready", req1_ready, mRdy1);
      check("stall_cnt", stall_cnt, mStall);
      check("zero_wr_cnt", zero_wr_cnt, mZero);
      check("BusA_out", BusA_out, expRead(RA_in));
      check("BusB_out", BusB_out, expRead(RB_in));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    Resetb = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    RA_in = '0; RB_in = '0;
    step();
    checkEn = 1'b1;
    check("rst_RegWr", RegWr, 1'b0);
    check("rst_RW", RW, 0);
    check("rst_BusW", BusW, 0);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_stall", stall_cnt, 0);
    check("rst_zero", zero_wr_cnt, 0);
    step();
    Resetb = 1'b1;
    step();

    // Single requester streaming addr 1..5
    for (int i = 1; i <= 5; i++) begin
      check("stream_ready", req0_ready, 1'b1);
      req0_valid = 1'b1; req0_addr = AW'(i); req0_data = 32'h10 + i;
      step();
    end
    idle(3);
    for (int i = 1; i <= 5; i++) begin
      RA_in = AW'(i);
      #1 check("stream_rd", BusA_out, 32'h10 + i);
      step();
    end

    // Contention for six cycles
    req0_addr = 5'd3; req0_data = 32'hA0A0A0A0;
    req1_addr = 5'd4; req1_data = 32'hB0B0B0B0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (6) step();
    idle(4);
    check("contend_stall", stall_cnt, 16'd6);
    RA_in = 5'd3; RB_in = 5'd4;
    #1 check("contend_rdA", BusA_out, 32'hA0A0A0A0);
    check("contend_rdB", BusB_out, 32'hB0B0B0B0);
    step();

    // Write to $0
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h12345678;
    step();
    idle(3);
    check("zero_cnt", zero_wr_cnt, 16'd1);
    RA_in = 5'd0;
    #1 check("zero_rd", BusA_out, 32'h0);
    step();

    // Reset while both slots are loaded and a write is on the port
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hDEADBEEF;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hCAFEF00D;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    check("mid_RegWr_pre", RegWr, 1'b1);
    #1 Resetb = 1'b0;
    #1 check("mid_RegWr", RegWr, 1'b0);
    check("mid_ready0", req0_ready, 1'b0);
    check("mid_ready1", req1_ready, 1'b0);
    step();
    step();
    Resetb = 1'b1;
    idle(3);
    check("mid_stall", stall_cnt, 0);
    check("mid_zero", zero_wr_cnt, 0);
    RA_in = 5'd10; RB_in = 5'd11;
    #1 check("mid_rdA", BusA_out, 32'h0);
    check("mid_rdB", BusB_out, 32'h0);
    step();

    // Same address, requester 0 wins first after reset
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hAAAA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hBBBB;
    step();
    idle(4);
    RA_in = 5'd7;
    #1 check("same_addr", BusA_out, 32'hBBBB);
    step();

    // Read of an address being written this cycle
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    step();
    idle(3);
    RA_in = 5'd9; RB_in = 5'd0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hDEAD;
    step();
    req0_valid = 1'b0;
    step();
    check("byp_RegWr", RegWr, 1'b1);
`ifdef RF_BYPASS_EN
    check("byp_busA", BusA_out, 32'hDEAD);
`else
    check("byp_busA", BusA_out, 32'h99);
`endif
    check("byp_busB", BusB_out, 32'h0);
    idle(3);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
